// File: rtl/serial_adder_pkg.sv
// Shared definitions for the digit-serial adder: FSM state encoding and
// the sizing helper for the digit counter.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Counter must hold every value from 0 up to and including n.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell; DIGIT of these form the ripple chain of serial_adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder: one DIGIT-wide ripple chain reused over WIDTH/DIGIT
// cycles, with a start/busy/done handshake and registered sum/carry/overflow.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             cy;

  logic [DIGIT:0]   chain;
  logic [DIGIT-1:0] dsum;
  logic             top_cin;
  logic [WIDTH-1:0] acc_next;

  // Ripple chain: cell i adds bit i of the current digit.
  assign chain[0] = cy;
  for (genvar i = 0; i < DIGIT; i++) begin : g_cell
    full_adder u_fa (
      .a     (a_sr[i]),
      .b     (b_sr[i]),
      .cin   (chain[i]),
      .sum   (dsum[i]),
      .carry (chain[i+1])
    );
  end
  assign top_cin = chain[DIGIT-1];

  // Digits enter the accumulation from the MSB end; after N shifts the first
  // digit has reached bit 0. Only the upper WIDTH-DIGIT bits need storage
  // because the lowest digit of the next value is always the fresh dsum.
  if (N == 1) begin : g_acc_none
    assign acc_next = dsum;
  end else begin : g_acc
    logic [WIDTH-DIGIT-1:0] acc_q;

    assign acc_next = {dsum, acc_q};

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        acc_q <= '0;
      end else if (state == S_RUN) begin
        acc_q <= acc_next[WIDTH-1:DIGIT];
      end
    end
  end

  // NOTE: every register here is sequential state, so it is assigned only
  // with <= and reset explicitly; mixing in = would create ordering races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      a_sr     <= '0;
      b_sr     <= '0;
      cy       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            cy    <= cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end

        S_RUN: begin
          a_sr <= a_sr >> DIGIT;
          b_sr <= b_sr >> DIGIT;
          cy   <= chain[DIGIT];
          cnt  <= cnt + 1'b1;
          // The final digit's top cell sits at bit WIDTH-1, which is where
          // signed overflow is judged.
          if (cnt == LAST) begin
            sum      <= acc_next;
            carry    <= chain[DIGIT];
            overflow <= top_cin ^ chain[DIGIT];
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= S_DONE;
          end
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: several WIDTH/DIGIT configurations,
// directed vectors, random regression, handshake and reset-abort sequences.
module tb_serial_adder;

  typedef struct {
    logic [15:0] sum;
    logic        carry;
    logic        ovf;
    int          due;
  } exp_t;

  typedef struct packed {
    logic [4:0]  mask;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s;
    logic        c;
    logic        v;
  } vec_t;

  // mask bit k selects configuration k; expected values computed by hand.
  localparam vec_t VECS [6] = '{
    '{5'b00111, 16'h005A, 16'h003C, 1'b0, 16'h0096, 1'b0, 1'b1},
    '{5'b00111, 16'h00FF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0},
    '{5'b00111, 16'h00FF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0},
    '{5'b00111, 16'h0080, 16'h0080, 1'b0, 16'h0000, 1'b1, 1'b1},
    '{5'b01000, 16'h1234, 16'hFEDC, 1'b1, 16'h1111, 1'b1, 1'b0},
    '{5'b01000, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1}
  };

  logic clk;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  int   n_fin = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                 input logic c, input int due);
    logic [16:0] full;
    logic [16:0] m;
    exp_t e;
    full   = {1'b0, a} + {1'b0, b} + {16'b0, c};
    m      = (17'd1 << w) - 17'd1;
    e.sum  = 16'(full & m);
    e.carry = full[w];
    e.ovf  = (a[w-1] == b[w-1]) && (full[w-1] != a[w-1]);
    e.due  = due;
    return e;
  endfunction

  // Configs 0..3 run directed vectors plus random regression; config 4 runs
  // the handshake and reset-abort sequences.
  for (genvar k = 0; k < 5; k++) begin : g_cfg
    localparam int W = (k == 3) ? 16 : 8;
    localparam int D = (k == 1) ? 2 : (k == 2) ? 8 : (k == 3) ? 4 : 1;
    localparam int N = W / D;

    logic         rst_b, start, cin, busy, done, carry, overflow;
    logic         prev_done = 1'b0;
    logic [W-1:0] a, b, sum;
    exp_t         q[$];

    serial_adder #(.WIDTH(W), .DIGIT(D)) u_dut (
      .clk      (clk),
      .rst      (rst_b),
      .start    (start),
      .a        (a),
      .b        (b),
      .cin      (cin),
      .busy     (busy),
      .done     (done),
      .sum      (sum),
      .carry    (carry),
      .overflow (overflow)
    );

    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                         output int acc_cyc);
      int guard;
      guard = 0;
      @(negedge clk);
      while (busy && guard < 100) begin
        @(negedge clk);
        guard++;
      end
      check($sformatf("cfg%0d idle_before_start", k), busy, 0);
      a = ia;
      b = ib;
      cin = ic;
      start = 1'b1;
      @(posedge clk);
      #1;
      acc_cyc = cyc;
      check($sformatf("cfg%0d busy_after_accept", k), busy, 1);
      start = 1'b0;
    endtask

    task automatic drain();
      int guard;
      guard = 0;
      while (q.size() != 0 && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      check($sformatf("cfg%0d results_drained", k), q.size(), 0);
    endtask

    always @(negedge clk) begin
      exp_t x;
      if (done) begin
        check($sformatf("cfg%0d done_without_busy", k), busy, 0);
        check($sformatf("cfg%0d done_one_cycle", k), prev_done, 0);
        check($sformatf("cfg%0d done_expected", k), q.size() != 0, 1);
        if (q.size() != 0) begin
          x = q.pop_front();
          check($sformatf("cfg%0d sum", k), sum, x.sum[W-1:0]);
          check($sformatf("cfg%0d carry", k), carry, x.carry);
          check($sformatf("cfg%0d overflow", k), overflow, x.ovf);
          check($sformatf("cfg%0d latency_cycle", k), cyc, x.due);
        end
      end
      prev_done <= done;
    end

    if (k < 4) begin : g_rand
      initial begin
        int e;
        logic [W-1:0] ra, rb;
        logic rc;
        start = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        rst_b = 1'b1;
        #22 rst_b = 1'b0;
        for (int i = 0; i < 6; i++) begin
          if (VECS[i].mask[k]) begin
            issue(W'(VECS[i].a), W'(VECS[i].b), VECS[i].cin, e);
            q.push_back(exp_t'{VECS[i].s, VECS[i].c, VECS[i].v, e + N});
          end
        end
        for (int i = 0; i < 1000; i++) begin
          ra = W'($urandom);
          rb = W'($urandom);
          rc = 1'($urandom);
          issue(ra, rb, rc, e);
          q.push_back(model(W, 16'(ra), 16'(rb), rc, e + N));
        end
        drain();
        n_fin++;
      end
    end else begin : g_seq
      initial begin
        int e, n_done;
        start = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        rst_b = 1'b1;
        #22 rst_b = 1'b0;
        @(negedge clk);
        check("seq reset busy", busy, 0);
        check("seq reset done", done, 0);
        check("seq reset sum", sum, 0);
        check("seq reset carry", carry, 0);
        check("seq reset overflow", overflow, 0);

        // A start mid-run is ignored; start held through DONE begins a
        // second operation on the following edge.
        issue(8'h11, 8'h22, 1'b0, e);
        q.push_back(exp_t'{16'h0033, 1'b0, 1'b0, e + 8});
        while (cyc < e + 2) @(negedge clk);
        a = 8'hAA;
        b = 8'h55;
        cin = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("seq busy_ignores_start", busy, 1);
        while (cyc < e + 7) @(negedge clk);
        a = 8'hC8;
        b = 8'h64;
        cin = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        check("seq done_at_e8", done, 1);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("seq busy_after_back_to_back", busy, 1);
        q.push_back(exp_t'{16'h002D, 1'b1, 1'b0, e + 17});
        drain();

        // Reset four edges into an operation discards it and clears outputs.
        issue(8'hFF, 8'hFF, 1'b0, e);
        repeat (4) @(posedge clk);
        #1 rst_b = 1'b1;
        #1;
        check("seq abort busy", busy, 0);
        check("seq abort done", done, 0);
        check("seq abort sum", sum, 0);
        check("seq abort carry", carry, 0);
        check("seq abort overflow", overflow, 0);
        @(negedge clk);
        rst_b = 1'b0;
        n_done = 0;
        repeat (20) begin
          @(negedge clk);
          if (done) n_done++;
        end
        check("seq no_done_after_abort", n_done, 0);

        issue(8'h5A, 8'h3C, 1'b0, e);
        q.push_back(exp_t'{16'h0096, 1'b0, 1'b1, e + 8});
        drain();
        n_fin++;
      end
    end
  end

  initial begin
    int guard;
    guard = 0;
    while (n_fin < 5 && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    check("all_configs_finished", n_fin, 5);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised digit-serial adder that replaces the single-bit combinational full adder cell wherever wide operands must be summed with minimal logic. It reuses one chain of DIGIT full-adder cells over WIDTH/DIGIT cycles, carrying between digits in a flip-flop. A start/busy/done handshake frames each operation. It sits beside the datapath as a small-area arithmetic engine and returns sum, carry-out and signed overflow.

## Interface

- WIDTH, 8, operand and sum width in bits; must be a multiple of DIGIT.
- DIGIT, 1, bits processed per cycle (1 = pure bit-serial). N = WIDTH/DIGIT is the number of digit cycles.

- clk  input  1  rising-edge clock; the block's only clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only while not busy.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- cin  input  1  carry-in; captured on the accepting edge.
- busy  output  1  high while digits are being processed.
- done  output  1  one-cycle pulse; sum, carry and overflow are valid from this cycle on.
- sum  output  WIDTH  result (a + b + cin) mod 2^WIDTH.
- carry  output  1  carry out of bit WIDTH-1.
- overflow  output  1  signed overflow: carry into the MSB XOR carry out of the MSB.

## Operation

- States:
  - IDLE: waiting for a request.
  - RUN: processing digits.
  - DONE: result just completed.
- IDLE or DONE, start=1 -> RUN:
  - a, b and cin load into internal shift registers.
  - The carry flop is set to cin.
  - The digit counter clears.
- IDLE or DONE, start=0 -> IDLE.
- RUN, each edge:
  - Add the low DIGIT bits of the a and b shift registers plus the carry flop through the DIGIT-cell ripple chain.
  - Shift the digit sum into the accumulation register from the MSB end.
  - Shift both operand registers right by DIGIT.
  - Store the chain carry-out in the carry flop.
  - Increment the counter.
- RUN, Nth digit edge -> DONE:
  - The accumulation register (including the final digit), the final carry and the overflow are copied to sum, carry and overflow.
- start while in RUN is ignored; no queueing.
- sum, carry and overflow are registered and change only at completion edges. They hold the previous result during RUN and indefinitely in IDLE.
- overflow is taken from the top cell of the final digit: the cell carry-in at bit WIDTH-1 XOR the cell carry-out.
- Arithmetic is unsigned modulo 2^WIDTH. The same sum is valid for two's-complement operands, with overflow flagging signed error.

## Timing

- Reset value: state IDLE. busy=0, done=0, sum=0, carry=0, overflow=0. Counter, carry flop and shift registers are all 0.
- Accepting edge E: busy=1 from E.
- Completion edge E+N: busy=0, done=1, results updated. Latency is N cycles from the accepting edge.
- Edge E+N+1:
  - done=0.
  - If start=1 at E+N+1, that edge accepts a new operation and busy=1. Back-to-back throughput is one result per N+1 cycles.
- done is never high for more than one cycle. done and busy are never both high.
- Reset asserted mid-RUN aborts immediately: outputs return to their reset values, no done is issued, and the partial result is discarded.
- N=1 (DIGIT=WIDTH) is legal: busy is high for one cycle and done follows on the next edge.

## Structure

- Shared package serial_adder_pkg holds the state encoding constants (S_IDLE, S_RUN, S_DONE, 2 bits) and a function computing the counter width, clog2(N+1).
- Sub-module full_adder, the one-bit cell (a, b, cin -> sum, carry).
  - DIGIT instances are chained in a generate loop.
  - The top instance exposes its carry-in for the overflow computation.
- Top-level contents: FSM, counter, operand shift registers, accumulation register, carry flop and output registers. The target is 150–250 lines.

## Test plan

- WIDTH=8, DIGIT=1, start with a=0x5A, b=0x3C, cin=0:
  - busy is high for 8 cycles.
  - done pulses on edge E+8 with sum=0x96, carry=0, overflow=1.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, carry=1, overflow=0. a=0xFF, b=0x00, cin=1 -> sum=0x00, carry=1, overflow=0. a=0x80, b=0x80, cin=0 -> sum=0x00, carry=1, overflow=1.
- start pulsed at E+3 with different operands:
  - It is ignored; the result equals the first operation.
  - start held high through the DONE cycle starts a second operation whose done arrives at E+17.
- rst asserted at E+4 of an operation:
  - All outputs are 0 in the same cycle, including the previous result.
  - No done appears in the following 20 cycles.
  - A fresh start then completes normally.
- WIDTH=16, DIGIT=4, a=0x1234, b=0xFEDC, cin=1:
  - done arrives at E+4 with sum=0x1111, carry=1, overflow=0.
- Random regression (≥1000 ops per config, DIGIT ∈ {1, 2, 8} at WIDTH=8):
  - sum, carry and overflow match a + b + cin.
  - The latency is exactly N in every operation.
